fwd_hazard_ctrl: RTL and testbench
==================================

// Module: fwd_hazard_ctrl
// PURPOSE
//  Forwarding/hazard controller for the EX stage of the 5-stage pipeline.
//  Tracks the destination register of each in-flight instruction in a shadow EX->MEM->WB pipe.
//  Drives the 2-bit selects of the two 32-bit 3-input operand muxes (A and B): 00 regfile, 01 EX/MEM, 10 MEM/WB.
//  Detects load-use hazards, stalls ID for one cycle and inserts an EX bubble.
// PARAMETERS
//  REG_ADDR_W  5   register index width; index 0 is hardwired zero and is never forwarded
//  CNT_W       16  width of the saturating stall counter
// PORTS
//  clk           in   1           rising-edge clock
//  rst           in   1           asynchronous, active-high reset
//  id_valid      in   1           ID holds a valid instruction
//  id_rs         in   REG_ADDR_W  ID source register A
//  id_rt         in   REG_ADDR_W  ID source register B
//  id_rd         in   REG_ADDR_W  ID destination register
//  id_reg_write  in   1           ID instruction writes rd
//  id_mem_read   in   1           ID instruction is a load
//  flush         in   1           branch taken: squash the instruction entering EX
//  stall         out  1           hold PC and IF/ID this cycle (combinational)
//  fwd_a_sel     out  2           select for operand-A mux
//  fwd_b_sel     out  2           select for operand-B mux
//  ex_valid      out  1           EX slot holds a real (non-bubble) instruction
//  stall_count   out  CNT_W       saturating count of stall cycles
// BEHAVIOUR
//  Shadow slots (registers):
//   EX  {valid,rs,rt,rd,reg_write,mem_read}
//   MEM {valid,rd,reg_write,mem_read}
//   WB  {valid,rd,reg_write}
//  Reset: all slots invalid, fields 0; stall=0, fwd_*_sel=00, ex_valid=0, stall_count=0.
//  Each clock:
//   WB<=MEM and MEM<=EX, unconditionally.
//   EX<=ID fields with valid=id_valid, except EX.valid<=0 when stall or flush is high.
//  stall = id_valid & EX.valid & EX.mem_read & EX.rd!=0 & (EX.rd==id_rs | EX.rd==id_rt) & ~flush.
//  Flush and stall together: flush wins, stall=0, bubble inserted.
//  A stall lasts exactly one cycle. Next cycle the load is in MEM, the bubble in EX, and the stall drops.
//  Forwarding (per operand X in {rs,rt}) is combinational from slot registers only, with zero ID-to-select latency
//  once the instruction is in EX:
//   01 if MEM.valid & MEM.reg_write & MEM.rd!=0 & MEM.rd==EX.X & ~MEM.mem_read
//   10 else if WB.valid & WB.reg_write & WB.rd!=0 & WB.rd==EX.X
//   00 otherwise, including EX.valid=0.
//  MEM has priority over WB: the newest value wins when both match.
//  Select 11 is never driven.
//  A load in MEM matching EX.X is unreachable (the stall prevents it). It is asserted never to occur.
//  stall_count increments on every cycle stall=1 and saturates at 2^CNT_W-1.
//  Reset mid-operation clears all slots; no stall or forward is produced in the following cycle.
// STRUCTURE
//  Package fwd_hazard_pkg:
//   localparams FWD_REG=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10
//   packed slot typedefs for EX, MEM and WB
//  Sub-module fwd_select: combinational priority compare for one operand.
//   Instantiated twice, for rs and rt.
//  Top holds the slot registers, the stall logic and the counter.
// TESTING
//  1 ID add r3 writes r3, next ID uses r3 as rs
//    -> cycle the consumer is in EX: fwd_a_sel=01, fwd_b_sel=00.
//  2 writer r4, unrelated instr, consumer rt=r4
//    -> fwd_b_sel=10.
//    Same plus MEM writer also r4 -> fwd_b_sel=01.
//  3 load r5, then consumer rs=r5
//    -> stall=1 for exactly 1 cycle, ex_valid=0 next cycle, then fwd_a_sel=10, stall_count=1.
//  4 load r5 in EX with consumer in ID and flush=1 in the same cycle
//    -> stall=0, ex_valid=0 next cycle, stall_count unchanged.
//  5 writer r0, consumer rs=r0
//    -> fwd_a_sel=00.
//    Assert rst mid-stream -> all outputs 0 immediately (async).
//  6 CNT_W=2, four consecutive load-use pairs
//    -> stall_count saturates at 3.

Source files
------------

// File: rtl/fwd_hazard_pkg.sv
// Shared types and select encodings for the EX-stage forwarding/hazard controller.
// Slot fields take their register-index width from SLOT_ADDR_W.
package fwd_hazard_pkg;

  localparam int SLOT_ADDR_W = 5;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef logic [SLOT_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rs;
    reg_addr_t rt;
    reg_addr_t rd;
    logic      reg_write;
    logic      mem_read;
  } ex_slot_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    logic      reg_write;
    logic      mem_read;
  } mem_slot_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    logic      reg_write;
  } wb_slot_t;

endpackage

// File: rtl/fwd_hazard_ctrl_select.sv
// Priority forwarding select for one EX source operand: the newest producer (MEM) beats WB.
module fwd_select
  import fwd_hazard_pkg::*;
(
  input  logic      ex_valid,
  input  reg_addr_t src,
  input  mem_slot_t mem_slot,
  input  wb_slot_t  wb_slot,
  output logic [1:0] sel
);

  // A load sitting in MEM has no data yet, so it never qualifies as an EX/MEM source.
  always_comb begin
    sel = FWD_REG;
    if (ex_valid && (src != '0)) begin
      if (mem_slot.valid && mem_slot.reg_write && !mem_slot.mem_read && (mem_slot.rd == src))
        sel = FWD_EXMEM;
      else if (wb_slot.valid && wb_slot.reg_write && (wb_slot.rd == src))
        sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding and load-use hazard controller with a shadow EX->MEM->WB destination pipe.
// REG_ADDR_W must equal SLOT_ADDR_W from the package.
module fwd_hazard_ctrl
  import fwd_hazard_pkg::*;
#(
  parameter int REG_ADDR_W = SLOT_ADDR_W,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic                  stall,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  ex_valid,
  output logic [CNT_W-1:0]      stall_count
);

  ex_slot_t  ex_p0;
  mem_slot_t mem_p1;
  wb_slot_t  wb_p2;
  logic      load_hit_in_mem;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Flush squashes the instruction entering EX, so it also cancels any stall on it.
  always_comb begin
    stall = id_valid && ex_p0.valid && ex_p0.mem_read && (ex_p0.rd != '0) &&
            ((ex_p0.rd == id_rs) || (ex_p0.rd == id_rt)) && !flush;
  end

  // ID -> EX (p0) -> MEM (p1) -> WB (p2)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_p0       <= '0;
      mem_p1      <= '0;
      wb_p2       <= '0;
      stall_count <= '0;
    end else begin
      wb_p2  <= '{valid: mem_p1.valid, rd: mem_p1.rd, reg_write: mem_p1.reg_write};
      mem_p1 <= '{valid: ex_p0.valid, rd: ex_p0.rd, reg_write: ex_p0.reg_write,
                  mem_read: ex_p0.mem_read};
      ex_p0  <= '{valid: id_valid && !stall && !flush, rs: id_rs, rt: id_rt, rd: id_rd,
                  reg_write: id_reg_write, mem_read: id_mem_read};
      if (stall)
        stall_count <= sat_inc(stall_count);
    end
  end

  assign ex_valid = ex_p0.valid;

  fwd_select u_sel_a (
    .ex_valid (ex_p0.valid),
    .src      (ex_p0.rs),
    .mem_slot (mem_p1),
    .wb_slot  (wb_p2),
    .sel      (fwd_a_sel)
  );

  fwd_select u_sel_b (
    .ex_valid (ex_p0.valid),
    .src      (ex_p0.rt),
    .mem_slot (mem_p1),
    .wb_slot  (wb_p2),
    .sel      (fwd_b_sel)
  );

  // The load-use stall guarantees a load never reaches MEM while its consumer is in EX.
  assign load_hit_in_mem = ex_p0.valid && mem_p1.valid && mem_p1.mem_read && (mem_p1.rd != '0) &&
                           ((mem_p1.rd == ex_p0.rs) || (mem_p1.rd == ex_p0.rt));

  a_no_load_hit_in_mem: assert property (@(posedge clk) disable iff (rst) !load_hit_in_mem);

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: an instruction-history model predicts each cycle's outputs.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_reg_write, id_mem_read, flush;

  logic        stall, ex_valid;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_count;
  logic        stall_s, ex_valid_s;
  logic [1:0]  fwd_a_sel_s, fwd_b_sel_s;
  logic [1:0]  stall_count_s;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .stall(stall), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .ex_valid(ex_valid),
    .stall_count(stall_count)
  );

  fwd_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .stall(stall_s), .fwd_a_sel(fwd_a_sel_s), .fwd_b_sel(fwd_b_sel_s), .ex_valid(ex_valid_s),
    .stall_count(stall_count_s)
  );

  typedef struct {
    logic       v;
    logic [4:0] rs, rt, rd;
    logic       rw, mr;
  } ins_t;

  typedef struct {
    logic        stall;
    logic [1:0]  a, b;
    logic        exv;
    logic [15:0] c16;
    logic [1:0]  c2;
  } exp_t;

  exp_t sbq[$];
  ins_t hist[$];          // hist[0] = instruction in EX, [1] one older, [2] two older
  int unsigned cnt16;
  int unsigned cnt2;
  int errors = 0;
  int checks = 0;

  function automatic ins_t mk(logic v, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                              logic rw, logic mr);
    ins_t i;
    i.v = v; i.rs = rs; i.rt = rt; i.rd = rd; i.rw = rw; i.mr = mr;
    return i;
  endfunction

  function automatic void model_reset();
    hist.delete();
    for (int k = 0; k < 3; k++) hist.push_back(mk(0, 0, 0, 0, 0, 0));
    cnt16 = 0;
    cnt2  = 0;
  endfunction

  // Newest older writer of x wins; a load one step ahead has no data and is skipped.
  function automatic logic [1:0] model_fwd(logic [4:0] x);
    if (!hist[0].v || x == 0) return 2'b00;
    for (int age = 1; age <= 2; age++) begin
      if (hist[age].v && hist[age].rw && hist[age].rd == x) begin
        if (age == 1 && hist[age].mr) continue;
        return (age == 1) ? 2'b01 : 2'b10;
      end
    end
    return 2'b00;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic cycle(input ins_t in, input logic fl, input logic r, output logic st);
    exp_t e;
    ins_t nxt;
    @(negedge clk);
    rst = r;
    id_valid = in.v; id_rs = in.rs; id_rt = in.rt; id_rd = in.rd;
    id_reg_write = in.rw; id_mem_read = in.mr; flush = fl;
    if (r) model_reset();
    e.stall = in.v && hist[0].v && hist[0].mr && hist[0].rd != 0 &&
              (hist[0].rd == in.rs || hist[0].rd == in.rt) && !fl;
    e.a   = model_fwd(hist[0].rs);
    e.b   = model_fwd(hist[0].rt);
    e.exv = hist[0].v;
    e.c16 = cnt16[15:0];
    e.c2  = cnt2[1:0];
    sbq.push_back(e);
    if (!r) begin
      nxt = in;
      nxt.v = in.v && !e.stall && !fl;
      hist.push_front(nxt);
      void'(hist.pop_back());
      if (e.stall) begin
        if (cnt16 < 65535) cnt16++;
        if (cnt2 < 3) cnt2++;
      end
    end
    st = e.stall;
  endtask

  // ID holds its instruction while stalled, as the real front end would.
  task automatic issue(input ins_t in, input logic fl);
    logic st;
    cycle(in, fl, 1'b0, st);
    if (st) cycle(in, 1'b0, 1'b0, st);
  endtask

  task automatic nops(input int n);
    for (int k = 0; k < n; k++) issue(mk(0, 0, 0, 0, 0, 0), 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("stall",         {15'd0, stall},         {15'd0, e.stall});
        chk("fwd_a_sel",     {14'd0, fwd_a_sel},     {14'd0, e.a});
        chk("fwd_b_sel",     {14'd0, fwd_b_sel},     {14'd0, e.b});
        chk("ex_valid",      {15'd0, ex_valid},      {15'd0, e.exv});
        chk("stall_count",   stall_count,            e.c16);
        chk("sat_stall",     {15'd0, stall_s},       {15'd0, e.stall});
        chk("sat_fwd_a",     {14'd0, fwd_a_sel_s},   {14'd0, e.a});
        chk("sat_fwd_b",     {14'd0, fwd_b_sel_s},   {14'd0, e.b});
        chk("sat_ex_valid",  {15'd0, ex_valid_s},    {15'd0, e.exv});
        chk("sat_count",     {14'd0, stall_count_s}, {14'd0, e.c2});
      end
    end
  end

  initial begin : driver
    logic st;
    logic [4:0] rs, rt, rd;
    logic rw, mr, v, fl;
    rst = 1'b1;
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_reg_write = 0; id_mem_read = 0; flush = 0;
    model_reset();
    cycle(mk(0, 0, 0, 0, 0, 0), 1'b0, 1'b1, st);
    cycle(mk(0, 0, 0, 0, 0, 0), 1'b0, 1'b1, st);
    nops(2);

    // producer r3 then consumer rs=r3
    issue(mk(1, 1, 2, 3, 1, 0), 1'b0);
    issue(mk(1, 3, 0, 7, 1, 0), 1'b0);
    nops(3);
    // writer r4, unrelated, consumer rt=r4; then two r4 writers back to back
    issue(mk(1, 1, 1, 4, 1, 0), 1'b0);
    issue(mk(1, 1, 2, 6, 1, 0), 1'b0);
    issue(mk(1, 2, 4, 7, 1, 0), 1'b0);
    nops(3);
    issue(mk(1, 1, 1, 4, 1, 0), 1'b0);
    issue(mk(1, 1, 1, 4, 1, 0), 1'b0);
    issue(mk(1, 2, 4, 7, 1, 0), 1'b0);
    nops(3);
    // load-use stall
    issue(mk(1, 1, 1, 5, 1, 1), 1'b0);
    issue(mk(1, 5, 2, 6, 1, 0), 1'b0);
    nops(3);
    // load-use coinciding with flush
    issue(mk(1, 1, 1, 5, 1, 1), 1'b0);
    issue(mk(1, 5, 2, 6, 1, 0), 1'b1);
    nops(3);
    // r0 is never forwarded
    issue(mk(1, 1, 1, 0, 1, 0), 1'b0);
    issue(mk(1, 0, 0, 6, 1, 0), 1'b0);
    // asynchronous reset while forwarding and a pending load are live
    issue(mk(1, 1, 1, 3, 1, 0), 1'b0);
    issue(mk(1, 3, 3, 5, 1, 1), 1'b0);
    cycle(mk(1, 5, 5, 6, 1, 0), 1'b0, 1'b1, st);
    cycle(mk(1, 5, 5, 6, 1, 0), 1'b0, 1'b1, st);
    issue(mk(1, 5, 5, 6, 1, 0), 1'b0);
    nops(3);
    // four load-use pairs saturate the 2-bit counter
    for (int k = 0; k < 4; k++) begin
      issue(mk(1, 2, 2, 5, 1, 1), 1'b0);
      issue(mk(1, 2, 5, 6, 1, 0), 1'b0);
    end
    nops(3);

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        cycle(mk(0, 0, 0, 0, 0, 0), 1'b0, 1'b1, st);
      end else begin
        v  = ($urandom_range(0, 7) != 0);
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        rw = ($urandom_range(0, 3) != 0);
        mr = rw && ($urandom_range(0, 2) == 0);
        fl = ($urandom_range(0, 9) == 0);
        issue(mk(v, rs, rt, rd, rw, mr), fl);
      end
    end
    nops(2);
    repeat (2) @(negedge clk);
    #4;
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
